// File: rtl/cond_move_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cond_move_unit
//  Description : Two-stage pipelined conditional-move evaluator (MOVZ/MOVN
//                class). Stage 1 captures the operands and a chunked
//                OR-reduction of the condition operand. Stage 2 completes the
//                zero test, decodes the destination write enable and presents
//                the result. A saturating counter tracks the moves taken.
//                Both stages use a valid/ready handshake, so the pipeline can
//                stall and be flushed.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       operand / data width
//    CHUNK       bits OR-reduced per chunk in stage 1 (must divide WIDTH)
//    CNT_W       width of the taken-move counter
//  Ports
//    Clk         rising-edge clock
//    Reset_n     asynchronous active-low reset
//    Flush       synchronous pipeline kill (clears both stage valids)
//    InValid     input beat valid
//    InReady     unit can accept a beat this cycle
//    Mode        00 MOVZ, 01 MOVN, 10 always write, 11 never write
//    Cond        condition operand (rt)
//    Data        value to move (rs)
//    Dest        destination register number
//    OutValid    result beat valid
//    OutReady    downstream accepts the result
//    OutWrite    destination write enable
//    OutData     Data passed through unchanged
//    OutDest     Dest passed through unchanged
//    TakenCount  saturating count of accepted results with OutWrite=1
// ============================================================================
module cond_move_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] Cond,
    input  logic [WIDTH-1:0] Data,
    input  logic [4:0]       Dest,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             OutWrite,
    output logic [WIDTH-1:0] OutData,
    output logic [4:0]       OutDest,
    output logic [CNT_W-1:0] TakenCount
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int NCHUNK = WIDTH / CHUNK;

    localparam logic [1:0] MODE_MOVZ   = 2'b00;
    localparam logic [1:0] MODE_MOVN   = 2'b01;
    localparam logic [1:0] MODE_ALWAYS = 2'b10;
    localparam logic [1:0] MODE_NEVER  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic              s1_valid;
    logic [1:0]        s1_mode;
    logic [WIDTH-1:0]  s1_data;
    logic [4:0]        s1_dest;
    logic [NCHUNK-1:0] s1_chunk_or;

    logic              s2_valid;
    logic              s2_write;
    logic [WIDTH-1:0]  s2_data;
    logic [4:0]        s2_dest;

    logic [CNT_W-1:0]  taken_cnt;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic s2_adv;
    logic s1_adv;
    logic in_accept;
    logic out_accept;

    assign s2_adv     = !s2_valid || OutReady;
    assign s1_adv     = !s1_valid || s2_adv;
    assign InReady    = s1_adv && !Flush;
    assign in_accept  = InValid && InReady;
    assign out_accept = s2_valid && OutReady;

    // ------------------------------------------------------------------------
    // Stage 1 condition pre-reduction: one OR per CHUNK-bit slice, so the
    // full-width zero test is split across the two stages.
    // ------------------------------------------------------------------------
    logic [NCHUNK-1:0] cond_chunk_or;

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        assign cond_chunk_or[g] = |Cond[g*CHUNK +: CHUNK];
    end

    // ------------------------------------------------------------------------
    // Stage 1 register
    // Payload only loads on an accepted beat, so a stalled stage never
    // changes its contents.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid    <= 1'b0;
            s1_mode     <= 2'b00;
            s1_data     <= '0;
            s1_dest     <= 5'd0;
            s1_chunk_or <= '0;
        end else if (Flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_accept;
            if (in_accept) begin
                s1_mode     <= Mode;
                s1_data     <= Data;
                s1_dest     <= Dest;
                s1_chunk_or <= cond_chunk_or;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 write-enable decode
    // ------------------------------------------------------------------------
    logic s1_nz;
    logic write_nxt;

    assign s1_nz = |s1_chunk_or;

    always_comb begin
        write_nxt = 1'b0;
        case (s1_mode)
            MODE_MOVZ:   write_nxt = !s1_nz;
            MODE_MOVN:   write_nxt = s1_nz;
            MODE_ALWAYS: write_nxt = 1'b1;
            MODE_NEVER:  write_nxt = 1'b0;
            default:     write_nxt = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Stage 2 register (drives the outputs directly)
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_valid <= 1'b0;
            s2_write <= 1'b0;
            s2_data  <= '0;
            s2_dest  <= 5'd0;
        end else if (Flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_write <= write_nxt;
                s2_data  <= s1_data;
                s2_dest  <= s1_dest;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Taken-move counter. Driven by the output handshake alone, so an accept
    // that coincides with Flush still counts and Flush never clears it.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            taken_cnt <= CNT_ZERO;
        end else if (out_accept && s2_write && (taken_cnt != CNT_MAX)) begin
            taken_cnt <= taken_cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign OutValid   = s2_valid;
    assign OutWrite   = s2_write;
    assign OutData    = s2_data;
    assign OutDest    = s2_dest;
    assign TakenCount = taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_move_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_move_unit
//  Description : Directed self-checking bench for cond_move_unit. The counter
//                is built 4 bits wide so saturation is reachable quickly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cond_move_unit;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int CNT_W = 4;

    logic             Clk;
    logic             Reset_n;
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] Cond;
    logic [WIDTH-1:0] Data;
    logic [4:0]       Dest;
    logic             OutValid;
    logic             OutReady;
    logic             OutWrite;
    logic [WIDTH-1:0] OutData;
    logic [4:0]       OutDest;
    logic [CNT_W-1:0] TakenCount;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int exp_cnt = 0;

    cond_move_unit #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .CNT_W (CNT_W)
    ) u_dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .Mode       (Mode),
        .Cond       (Cond),
        .Data       (Data),
        .Dest       (Dest),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutWrite   (OutWrite),
        .OutData    (OutData),
        .OutDest    (OutDest),
        .TakenCount (TakenCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] c,
                         input logic [31:0] d, input logic [4:0] r);
        InValid = v;
        Mode    = m;
        Cond    = c;
        Data    = d;
        Dest    = r;
    endtask

    // Watchdog: nothing in this bench should come close to this bound.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_n  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);

        // ---------------- reset state ----------------
        #12;
        check_eq("rst_outvalid", 64'(OutValid), 64'd0);
        check_eq("rst_outwrite", 64'(OutWrite), 64'd0);
        check_eq("rst_outdata",  64'(OutData),  64'd0);
        check_eq("rst_outdest",  64'(OutDest),  64'd0);
        check_eq("rst_count",    64'(TakenCount), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check_eq("rst_inready", 64'(InReady), 64'd1);
        tick();

        // ---------------- single MOVZ, two-cycle latency ----------------
        drive(1'b1, 2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 5'd5);
        tick();
        check_eq("t1_lat_s1", 64'(OutValid), 64'd0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        check_eq("t1_outvalid", 64'(OutValid), 64'd1);
        check_eq("t1_outwrite", 64'(OutWrite), 64'd1);
        check_eq("t1_outdata",  64'(OutData),  64'hDEAD_BEEF);
        check_eq("t1_outdest",  64'(OutDest),  64'd5);
        check_eq("t1_count_pre", 64'(TakenCount), 64'd0);
        tick();
        exp_cnt = 1;
        check_eq("t1_count", 64'(TakenCount), 64'(exp_cnt));
        check_eq("t1_drained", 64'(OutValid), 64'd0);

        // ---------------- back-to-back mode decode ----------------
        drive(1'b1, 2'b00, 32'h8000_0000, 32'h11, 5'd1);  // MOVZ, nz  -> 0
        tick();
        drive(1'b1, 2'b01, 32'h0000_0100, 32'h22, 5'd2);  // MOVN, nz  -> 1
        tick();
        check_eq("t2_b0_valid", 64'(OutValid), 64'd1);
        check_eq("t2_b0_write", 64'(OutWrite), 64'd0);
        check_eq("t2_b0_dest",  64'(OutDest),  64'd1);
        drive(1'b1, 2'b01, 32'h0000_0000, 32'h33, 5'd3);  // MOVN, zero -> 0
        tick();
        check_eq("t2_b1_write", 64'(OutWrite), 64'd1);
        check_eq("t2_b1_dest",  64'(OutDest),  64'd2);
        check_eq("t2_b1_data",  64'(OutData),  64'h22);
        drive(1'b1, 2'b11, 32'h0000_0000, 32'h44, 5'd4);  // never -> 0
        tick();
        check_eq("t2_b2_write", 64'(OutWrite), 64'd0);
        check_eq("t2_b2_dest",  64'(OutDest),  64'd3);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        check_eq("t2_b3_write", 64'(OutWrite), 64'd0);
        check_eq("t2_b3_dest",  64'(OutDest),  64'd4);
        exp_cnt = 2;
        check_eq("t2_count", 64'(TakenCount), 64'(exp_cnt));
        tick();
        check_eq("t2_drained", 64'(OutValid), 64'd0);
        check_eq("t2_count_hold", 64'(TakenCount), 64'(exp_cnt));

        // ---------------- backpressure: 2-deep buffering ----------------
        OutReady = 1'b0;
        drive(1'b1, 2'b10, 32'h0, 32'h1000, 5'd10);
        #1;
        check_eq("t3_rdy0", 64'(InReady), 64'd1);
        tick();
        drive(1'b1, 2'b10, 32'h0, 32'h1001, 5'd11);
        #1;
        check_eq("t3_rdy1", 64'(InReady), 64'd1);
        tick();
        drive(1'b1, 2'b10, 32'h0, 32'h1002, 5'd12);
        #1;
        check_eq("t3_rdy_full", 64'(InReady), 64'd0);
        tick();
        tick();
        check_eq("t3_stall_valid", 64'(OutValid), 64'd1);
        check_eq("t3_stall_data",  64'(OutData),  64'h1000);
        check_eq("t3_stall_dest",  64'(OutDest),  64'd10);
        check_eq("t3_stall_count", 64'(TakenCount), 64'(exp_cnt));
        OutReady = 1'b1;
        #1;
        check_eq("t3_rdy_release", 64'(InReady), 64'd1);
        tick();
        check_eq("t3_drain1", 64'(OutData), 64'h1001);
        drive(1'b1, 2'b10, 32'h0, 32'h1003, 5'd13);
        tick();
        check_eq("t3_drain2", 64'(OutData), 64'h1002);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        check_eq("t3_drain3", 64'(OutData), 64'h1003);
        check_eq("t3_drain3_dest", 64'(OutDest), 64'd13);
        tick();
        check_eq("t3_empty", 64'(OutValid), 64'd0);
        exp_cnt = 6;
        check_eq("t3_count", 64'(TakenCount), 64'(exp_cnt));

        // ---------------- flush with full pipeline, no output accept ----------------
        OutReady = 1'b0;
        drive(1'b1, 2'b10, 32'h0, 32'h2000, 5'd20);
        tick();
        drive(1'b1, 2'b10, 32'h0, 32'h2001, 5'd21);
        tick();
        drive(1'b1, 2'b10, 32'h0, 32'h2002, 5'd22);
        Flush = 1'b1;
        #1;
        check_eq("t4_rdy_flush", 64'(InReady), 64'd0);
        tick();
        Flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        check_eq("t4_flushed", 64'(OutValid), 64'd0);
        OutReady = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t4_no_ghost", 64'(OutValid), 64'd0);
        check_eq("t4_count", 64'(TakenCount), 64'(exp_cnt));

        // ---------------- output accept in the flush cycle still counts ----------------
        OutReady = 1'b0;
        drive(1'b1, 2'b10, 32'h0, 32'h3000, 5'd30);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        check_eq("t5_held", 64'(OutValid), 64'd1);
        Flush    = 1'b1;
        OutReady = 1'b1;
        tick();
        Flush = 1'b0;
        exp_cnt = 7;
        check_eq("t5_flush_valid", 64'(OutValid), 64'd0);
        check_eq("t5_flush_count", 64'(TakenCount), 64'(exp_cnt));

        // ---------------- counter saturation ----------------
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'b10, 32'h0, 32'h5000 + 32'(i), 5'(i));
            tick();
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        check_eq("t6_sat_count", 64'(TakenCount), 64'd15);
        check_eq("t6_sat_last",  64'(OutData),    64'h5013);

        // ---------------- asynchronous reset mid-flight ----------------
        OutReady = 1'b0;
        drive(1'b1, 2'b10, 32'h0, 32'h4000, 5'd7);
        tick();
        drive(1'b1, 2'b10, 32'h0, 32'h4001, 5'd8);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        check_eq("t7_inflight", 64'(OutValid), 64'd1);
        #1;
        Reset_n = 1'b0;
        #1;
        check_eq("t7_arst_valid", 64'(OutValid),   64'd0);
        check_eq("t7_arst_write", 64'(OutWrite),   64'd0);
        check_eq("t7_arst_data",  64'(OutData),    64'd0);
        check_eq("t7_arst_dest",  64'(OutDest),    64'd0);
        check_eq("t7_arst_count", 64'(TakenCount), 64'd0);
        @(negedge Clk);
        Reset_n  = 1'b1;
        OutReady = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t7_no_stale", 64'(OutValid), 64'd0);
        check_eq("t7_inready",  64'(InReady),  64'd1);
        check_eq("t7_count",    64'(TakenCount), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
